aq_cjpeg_bitpack: RTL and testbench
===================================

Name: aq_cjpeg_bitpack

Overview:
Entropy-coded bitstream packer for the JPEG encode path, the write-side counterpart of the decoder's word fetch and bit consume stage.
- Accepts variable-width Huffman code plus amplitude fields, MSB first.
- Inserts 0x00 after every 0xFF data byte.
- Pads to a byte boundary with 1s on flush and injects raw 16-bit markers with no stuffing.
- Packs bytes big-endian into 32-bit words for the output FIFO.

Parameters:
ACC_W, 64, bit accumulator width; must be ≥ 2×27+8.
MAX_CODE, 27, maximum code width (16-bit Huffman code + 11-bit amplitude).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
CodeEnable  in  1  code valid
CodeReady  out  1  block can accept a code this cycle
CodeData  in  27  code right-justified; bit [CodeWidth-1] is sent first
CodeWidth  in  5  width 0..27; 0 = no-op
Flush  in  1  pulse: pad with 1s to byte boundary, drain
MarkerEnable  in  1  pulse: send MarkerData after implicit flush
MarkerData  in  16  marker, e.g. 0xFFD9
MarkerLast  in  1  qualifies MarkerEnable: end of stream after the marker
DataOut  out  32  packed word; first byte in [31:24]
DataOutEnable  out  1  word valid (one-cycle write strobe)
DataOutFull  in  1  FIFO full; no write while high
DataOutBytes  out  3  valid bytes in DataOut, 1..4; <4 only when DataOutEnd
DataOutEnd  out  1  final word of stream
Idle  out  1  no state held, FSM in RUN, accumulator and packer empty

Behaviour:
Reset (rst low, async):
- AccCount=0, packer empty, FSM=RUN.
- CodeReady=1, DataOutEnable=0, DataOut=0, DataOutBytes=0, DataOutEnd=0, Idle=1.

Code accept:
- Handshake on CodeEnable&&CodeReady.
- CodeReady = FSM==RUN && AccCount ≤ ACC_W-MAX_CODE && no Flush/Marker pending.
- Accepted bits are appended below the current contents; AccCount += CodeWidth.
- Width 0 is accepted and changes nothing.

Byte stage, at most one byte per cycle into the packer:
- If StuffPending, push 0x00 and clear StuffPending.
- Otherwise, if AccCount ≥ 8, push the top byte and AccCount -= 8. If that byte is 0xFF, set StuffPending.
- The byte stage stalls while the packer is full and its word is not yet written.

Packer:
- Collects 4 bytes, then asserts DataOutEnable for one cycle when DataOutFull=0.
- Holds DataOut stable while DataOutFull=1.
- Loses no bytes.

Latency: a code accepted in cycle n makes its first byte available to the packer in n+1. The 4th byte of a word leaves on DataOut no earlier than the cycle after it enters the packer.

FSM:
- RUN
  - Flush → PAD.
  - MarkerEnable → PAD with marker pending.
  - If both arrive together, the marker takes precedence; a single pad is applied.
- PAD
  - If AccCount%8 ≠ 0, append (8-AccCount%8) 1-bits.
  - Then wait until AccCount=0 and StuffPending=0.
  - Pad bytes equal to 0xFF are stuffed like data.
  - Next state: MARK if a marker is pending, else RUN.
- MARK
  - Push MarkerData[15:8], then MarkerData[7:0], into the packer with no stuffing.
  - Next state: LAST if MarkerLast, else RUN.
- LAST
  - If the packer is non-empty, emit the partial word left-justified with unused low bytes = 0, DataOutBytes = count, DataOutEnd=1.
  - If the packer is empty, emit no extra word. In that case the last full word written in MARK carries DataOutEnd=1.
  - Then → RUN, and Idle returns to 1.

Boundary rules:
- Flush with AccCount%8==0 adds no pad bits.
- Flush/Marker pulses arriving outside RUN are ignored.
- The source must wait for CodeReady. CodeEnable while CodeReady=0 is dropped.
- Async reset mid-stream discards all buffered bits and bytes immediately; there is no partial output.

Decomposition:
- Shared package aq_cjpeg_pkg: FSM state encoding (RUN, PAD, MARK, LAST), MAX_CODE, stuff byte constants 8'hFF and 8'h00, marker constants SOI, EOI, RST0.
- One sub-module, aq_cjpeg_wordpack: byte-in/word-out packer with byte count, full hold, partial-flush and end flag.

Test Plan:
1. Four codes 0xFF, width 8, then marker 0xFFD9 with MarkerLast → words 0xFF00FF00, 0xFF00FF00, then 0xFFD90000 with DataOutBytes=2 and DataOutEnd=1.
2. Code 0b101 width 3, then MarkerEnable 0xFFD9 with MarkerLast → pad to 0xBF; single word 0xBFFFD900 with DataOutBytes=3 and DataOutEnd=1.
3. Hold DataOutFull=1 while streaming 27-bit codes → DataOutEnable stays 0 and DataOut is held; CodeReady falls once AccCount>37. After release, all words match the reference model byte for byte.
4. Pad producing 0xFF: code 0x1F width 5, then Flush → bytes 0xFF, 0x00; AccCount=0; Idle=1 once the word completes.
5. Width 0 codes interleaved with width 8 code 0x12 ×4 → exactly one word 0x12121212.
6. Assert rst low mid-word with 3 bytes in the packer → all outputs take reset values immediately. A fresh stream after release shows no residue.

Source files
------------

// File: rtl/aq_cjpeg_pkg.sv
// Shared constants and types for the JPEG entropy-coded bitstream packer.
package aq_cjpeg_pkg;

    localparam int unsigned ACC_W_DEFAULT = 64;
    localparam int unsigned MAX_CODE      = 27;
    localparam int unsigned WIDTH_W       = 5;
    localparam int unsigned MARKER_W      = 16;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned WORD_BYTES_W  = 3;

    localparam logic [7:0] STUFF_FF = 8'hFF;
    localparam logic [7:0] STUFF_00 = 8'h00;

    localparam logic [MARKER_W-1:0] MARKER_SOI  = 16'hFFD8;
    localparam logic [MARKER_W-1:0] MARKER_EOI  = 16'hFFD9;
    localparam logic [MARKER_W-1:0] MARKER_RST0 = 16'hFFD0;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PAD  = 2'd1,
        ST_MARK = 2'd2,
        ST_LAST = 2'd3
    } bp_state_e;

    // One byte travelling from the byte stage into the word packer.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byte_bus_t;

endpackage

// File: rtl/aq_cjpeg_wordpack.sv
// Byte-in / 32-bit-word-out packer: big-endian fill, holds while the FIFO is full,
// closes a partial word when the stream's final byte arrives.
module aq_cjpeg_wordpack
    import aq_cjpeg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  byte_bus_t               in_byte,
    output logic                    in_ready,
    output logic                    empty,
    output logic [WORD_W-1:0]       word_data,
    output logic                    word_valid,
    output logic [WORD_BYTES_W-1:0] word_bytes,
    output logic                    word_end,
    input  logic                    word_full
);

    logic [WORD_W-1:0]       buf_q,  buf_d;
    logic [WORD_BYTES_W-1:0] bcnt_q, bcnt_d;
    logic                    pend_q, pend_d;
    logic                    end_q,  end_d;
    logic                    wr;

    // A completed word leaves whenever the FIFO has room; the slot frees the same cycle.
    assign wr         = pend_q && !word_full;
    assign in_ready   = !pend_q || !word_full;
    assign empty      = (bcnt_q == '0);
    assign word_data  = buf_q;
    assign word_valid = wr;
    assign word_bytes = bcnt_q;
    assign word_end   = end_q;

    // Next-state: retire the written word, then place the incoming byte.
    always_comb begin
        buf_d  = buf_q;
        bcnt_d = bcnt_q;
        pend_d = pend_q;
        end_d  = end_q;
        if (wr) begin
            buf_d  = '0;
            bcnt_d = '0;
            pend_d = 1'b0;
            end_d  = 1'b0;
        end
        if (in_valid && in_ready) begin
            case (bcnt_d[1:0])
                2'd0:    buf_d[31:24] = in_byte.data;
                2'd1:    buf_d[23:16] = in_byte.data;
                2'd2:    buf_d[15:8]  = in_byte.data;
                default: buf_d[7:0]   = in_byte.data;
            endcase
            bcnt_d = bcnt_d + WORD_BYTES_W'(1);
            if (bcnt_d == WORD_BYTES_W'(4) || in_byte.last) begin
                pend_d = 1'b1;
            end
            if (in_byte.last) begin
                end_d = 1'b1;
            end
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q  <= '0;
            bcnt_q <= '0;
            pend_q <= 1'b0;
            end_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            bcnt_q <= bcnt_d;
            pend_q <= pend_d;
            end_q  <= end_d;
        end
    end

endmodule

// File: rtl/aq_cjpeg_bitpack.sv
// JPEG entropy bitstream packer: MSB-first bit accumulator, 0xFF stuffing,
// 1-padding on flush, raw marker injection, 32-bit word output.
module aq_cjpeg_bitpack
    import aq_cjpeg_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    CodeEnable,
    output logic                    CodeReady,
    input  logic [MAX_CODE-1:0]     CodeData,
    input  logic [WIDTH_W-1:0]      CodeWidth,
    input  logic                    Flush,
    input  logic                    MarkerEnable,
    input  logic [MARKER_W-1:0]     MarkerData,
    input  logic                    MarkerLast,
    output logic [WORD_W-1:0]       DataOut,
    output logic                    DataOutEnable,
    input  logic                    DataOutFull,
    output logic [WORD_BYTES_W-1:0] DataOutBytes,
    output logic                    DataOutEnd,
    output logic                    Idle
);

    localparam int unsigned CNT_W     = $clog2(ACC_W + 1);
    localparam int unsigned READY_MAX = ACC_W - MAX_CODE;

    bp_state_e            state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 stuff_q, stuff_d;
    logic                 pad_done_q, pad_done_d;
    logic                 mark_pend_q, mark_pend_d;
    logic                 mark_last_q, mark_last_d;
    logic                 mark_idx_q, mark_idx_d;
    logic [MARKER_W-1:0]  mark_data_q, mark_data_d;

    logic                 pk_valid, pk_ready, pk_empty;
    byte_bus_t            pk_in;
    logic [ACC_W-1:0]     app_bits;
    logic [CNT_W-1:0]     app_w;
    logic [CNT_W-1:0]     code_w;
    logic                 code_fire;

    function automatic logic [ACC_W-1:0] low_ones(input logic [CNT_W-1:0] n);
        low_ones = (ACC_W'(1) << n) - ACC_W'(1);
    endfunction

    assign code_w    = (CodeWidth > WIDTH_W'(MAX_CODE)) ? CNT_W'(MAX_CODE) : CNT_W'(CodeWidth);
    assign CodeReady = (state_q == ST_RUN) && (cnt_q <= CNT_W'(READY_MAX));
    assign code_fire = CodeEnable && CodeReady;
    assign Idle      = (state_q == ST_RUN) && (cnt_q == '0) && !stuff_q && pk_empty;

    // Byte stage, bit append and control FSM next-state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        stuff_d     = stuff_q;
        pad_done_d  = pad_done_q;
        mark_pend_d = mark_pend_q;
        mark_last_d = mark_last_q;
        mark_idx_d  = mark_idx_q;
        mark_data_d = mark_data_q;
        pk_valid    = 1'b0;
        pk_in       = '0;
        app_bits    = '0;
        app_w       = '0;

        // Byte source: marker bytes, then a pending stuff byte, then accumulator top byte.
        if (state_q == ST_MARK) begin
            pk_valid     = 1'b1;
            pk_in.data   = mark_idx_q ? mark_data_q[7:0] : mark_data_q[15:8];
            pk_in.last   = mark_idx_q && mark_last_q;
        end else if (stuff_q) begin
            pk_valid     = 1'b1;
            pk_in.data   = STUFF_00;
        end else if (cnt_q >= CNT_W'(8)) begin
            pk_valid     = 1'b1;
            pk_in.data   = acc_q[ACC_W-1 -: 8];
        end

        if (pk_valid && pk_ready && state_q != ST_MARK) begin
            if (stuff_q) begin
                stuff_d = 1'b0;
            end else begin
                acc_d   = acc_q << 8;
                cnt_d   = cnt_q - CNT_W'(8);
                stuff_d = (pk_in.data == STUFF_FF);
            end
        end

        // New bits land directly below whatever remains after this cycle's pop.
        if (code_fire) begin
            app_w    = code_w;
            app_bits = ACC_W'(CodeData) & low_ones(code_w);
        end else if (state_q == ST_PAD && !pad_done_q && cnt_q[2:0] != 3'd0) begin
            app_w    = CNT_W'(8) - CNT_W'(cnt_q[2:0]);
            app_bits = low_ones(app_w);
        end
        acc_d = acc_d | (app_bits << (CNT_W'(ACC_W) - cnt_d - app_w));
        cnt_d = cnt_d + app_w;

        case (state_q)
            ST_RUN: begin
                if (MarkerEnable) begin
                    state_d     = ST_PAD;
                    pad_done_d  = 1'b0;
                    mark_pend_d = 1'b1;
                    mark_data_d = MarkerData;
                    mark_last_d = MarkerLast;
                end else if (Flush) begin
                    state_d     = ST_PAD;
                    pad_done_d  = 1'b0;
                    mark_pend_d = 1'b0;
                end
            end
            ST_PAD: begin
                pad_done_d = 1'b1;
                if (pad_done_q && cnt_q == '0 && !stuff_q) begin
                    state_d    = mark_pend_q ? ST_MARK : ST_RUN;
                    mark_idx_d = 1'b0;
                end
            end
            ST_MARK: begin
                if (pk_ready) begin
                    if (mark_idx_q) begin
                        mark_idx_d  = 1'b0;
                        mark_pend_d = 1'b0;
                        state_d     = mark_last_q ? ST_LAST : ST_RUN;
                    end else begin
                        mark_idx_d  = 1'b1;
                    end
                end
            end
            ST_LAST: begin
                if (pk_empty) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Control and accumulator registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            acc_q       <= '0;
            cnt_q       <= '0;
            stuff_q     <= 1'b0;
            pad_done_q  <= 1'b0;
            mark_pend_q <= 1'b0;
            mark_last_q <= 1'b0;
            mark_idx_q  <= 1'b0;
            mark_data_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            stuff_q     <= stuff_d;
            pad_done_q  <= pad_done_d;
            mark_pend_q <= mark_pend_d;
            mark_last_q <= mark_last_d;
            mark_idx_q  <= mark_idx_d;
            mark_data_q <= mark_data_d;
        end
    end

    aq_cjpeg_wordpack u_wordpack (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (pk_valid),
        .in_byte    (pk_in),
        .in_ready   (pk_ready),
        .empty      (pk_empty),
        .word_data  (DataOut),
        .word_valid (DataOutEnable),
        .word_bytes (DataOutBytes),
        .word_end   (DataOutEnd),
        .word_full  (DataOutFull)
    );

endmodule

// File: tb/tb_aq_cjpeg_bitpack.sv
// Directed and randomized checks of the bitstream packer against a bit-queue model.
module tb_aq_cjpeg_bitpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CodeEnable = 1'b0;
    logic        CodeReady;
    logic [26:0] CodeData = '0;
    logic [4:0]  CodeWidth = '0;
    logic        Flush = 1'b0;
    logic        MarkerEnable = 1'b0;
    logic [15:0] MarkerData = '0;
    logic        MarkerLast = 1'b0;
    logic [31:0] DataOut;
    logic        DataOutEnable;
    logic        DataOutFull = 1'b0;
    logic [2:0]  DataOutBytes;
    logic        DataOutEnd;
    logic        Idle;

    aq_cjpeg_bitpack dut (
        .clk(clk), .rst(rst),
        .CodeEnable(CodeEnable), .CodeReady(CodeReady),
        .CodeData(CodeData), .CodeWidth(CodeWidth),
        .Flush(Flush), .MarkerEnable(MarkerEnable),
        .MarkerData(MarkerData), .MarkerLast(MarkerLast),
        .DataOut(DataOut), .DataOutEnable(DataOutEnable),
        .DataOutFull(DataOutFull), .DataOutBytes(DataOutBytes),
        .DataOutEnd(DataOutEnd), .Idle(Idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          n;
        bit          e;
    } wrd_t;

    int   total  = 0;
    int   passed = 0;
    wrd_t exp_q[$];
    wrd_t got_q[$];
    bit   mbits[$];
    logic [7:0] mpend[$];
    bit   rand_full  = 1'b0;
    bit   full_force = 1'b0;

    function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic void m_byte(input logic [7:0] b);
        wrd_t w;
        mpend.push_back(b);
        if (mpend.size() == 4) begin
            w.d = {mpend[0], mpend[1], mpend[2], mpend[3]};
            w.n = 4;
            w.e = 1'b0;
            exp_q.push_back(w);
            mpend.delete();
        end
    endfunction

    function automatic void m_drain();
        logic [7:0] b;
        while (mbits.size() >= 8) begin
            b = '0;
            for (int i = 0; i < 8; i++) b = {b[6:0], mbits.pop_front()};
            m_byte(b);
            if (b == 8'hFF) m_byte(8'h00);
        end
    endfunction

    function automatic void m_code(input logic [26:0] d, input int w);
        for (int i = w - 1; i >= 0; i--) mbits.push_back(d[i]);
        m_drain();
    endfunction

    function automatic void m_flush();
        while (mbits.size() % 8 != 0) mbits.push_back(1'b1);
        m_drain();
    endfunction

    function automatic void m_end();
        wrd_t w;
        if (mpend.size() > 0) begin
            w.d = '0;
            for (int i = 0; i < mpend.size(); i++) w.d = w.d | (32'(mpend[i]) << (24 - 8 * i));
            w.n = mpend.size();
            w.e = 1'b1;
            exp_q.push_back(w);
            mpend.delete();
        end else if (exp_q.size() > 0) begin
            w = exp_q.pop_back();
            w.e = 1'b1;
            exp_q.push_back(w);
        end
    endfunction

    function automatic void m_marker(input logic [15:0] m, input bit last);
        m_flush();
        m_byte(m[15:8]);
        m_byte(m[7:0]);
        if (last) m_end();
    endfunction

    // ---------------- monitors / drivers ----------------
    initial forever begin
        @(negedge clk);
        DataOutFull = rand_full ? ($urandom_range(0, 2) == 0) : full_force;
    end

    initial forever begin
        wrd_t w;
        @(negedge clk);
        #4;
        if (rst && DataOutEnable) begin
            w.d = DataOut;
            w.n = int'(DataOutBytes);
            w.e = DataOutEnd;
            got_q.push_back(w);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        int t = 0;
        while (!CodeReady && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!CodeReady) check("ready_timeout", 64'(CodeReady), 64'd1);
    endtask

    task automatic send(input logic [26:0] d, input int w);
        wait_ready();
        CodeEnable = 1'b1;
        CodeData   = d;
        CodeWidth  = 5'(w);
        m_code(d, w);
        @(negedge clk);
        CodeEnable = 1'b0;
    endtask

    task automatic pulse_flush();
        wait_ready();
        Flush = 1'b1;
        m_flush();
        @(negedge clk);
        Flush = 1'b0;
    endtask

    task automatic pulse_marker(input logic [15:0] m, input bit last);
        wait_ready();
        MarkerEnable = 1'b1;
        MarkerData   = m;
        MarkerLast   = last;
        m_marker(m, last);
        @(negedge clk);
        MarkerEnable = 1'b0;
        MarkerLast   = 1'b0;
    endtask

    task automatic drain_idle(input string tag);
        int t = 0;
        @(negedge clk);
        while (!Idle && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_idle"}, 64'(Idle), 64'd1);
    endtask

    function automatic void compare_words(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_word"},
                  {16'h0, got_q[i].d, 8'(got_q[i].n), 8'(got_q[i].e)},
                  {16'h0, exp_q[i].d, 8'(exp_q[i].n), 8'(exp_q[i].e)});
        end
        got_q.delete();
        exp_q.delete();
    endfunction

    function automatic void check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(CodeReady), 64'd1);
        check({tag, "_den"},   64'(DataOutEnable), 64'd0);
        check({tag, "_dout"},  64'(DataOut), 64'd0);
        check({tag, "_bytes"}, 64'(DataOutBytes), 64'd0);
        check({tag, "_end"},   64'(DataOutEnd), 64'd0);
        check({tag, "_idle"},  64'(Idle), 64'd1);
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [26:0] d;
        logic [31:0] held;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Stuffed data bytes followed by an end-of-image marker.
        repeat (4) send(27'hFF, 8);
        pulse_marker(16'hFFD9, 1'b1);
        drain_idle("t1");
        compare_words("t1");

        // Partial byte padded with ones before the marker.
        send(27'h5, 3);
        pulse_marker(16'hFFD9, 1'b1);
        drain_idle("t2");
        compare_words("t2");

        // Output back-pressure: no writes, word held, intake throttles.
        full_force = 1'b1;
        repeat (2) @(negedge clk);
        repeat (40) begin
            if (CodeReady) begin
                d = 27'($urandom);
                CodeEnable = 1'b1;
                CodeData   = d;
                CodeWidth  = 5'd27;
                m_code(d, 27);
            end else begin
                CodeEnable = 1'b0;
            end
            @(negedge clk);
        end
        CodeEnable = 1'b0;
        check("t3_ready_low", 64'(CodeReady), 64'd0);
        check("t3_no_write", 64'(got_q.size()), 64'd0);
        held = DataOut;
        repeat (5) @(negedge clk);
        check("t3_dout_hold", 64'(DataOut), 64'(held));
        check("t3_den_low", 64'(DataOutEnable), 64'd0);
        full_force = 1'b0;
        pulse_marker(16'hFFD9, 1'b1);
        drain_idle("t3");
        compare_words("t3");

        // Pad that produces 0xFF gets stuffed; packer keeps the partial word.
        send(27'h1F, 5);
        pulse_flush();
        repeat (20) @(negedge clk);
        check("t4_idle_partial", 64'(Idle), 64'd0);
        check("t4_no_write", 64'(got_q.size()), 64'd0);
        send(27'h34, 8);
        send(27'h56, 8);
        drain_idle("t4");
        compare_words("t4");

        // Zero-width codes are no-ops.
        for (int i = 0; i < 4; i++) begin
            send(27'($urandom), 0);
            send(27'h12, 8);
        end
        send(27'($urandom), 0);
        drain_idle("t5");
        compare_words("t5");

        // Asynchronous reset with three bytes sitting in the packer.
        send(27'hA1, 8);
        send(27'hB2, 8);
        send(27'hC3, 8);
        repeat (8) @(negedge clk);
        check("t6_idle_busy", 64'(Idle), 64'd0);
        check("t6_no_write", 64'(got_q.size()), 64'd0);
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        mbits.delete();
        mpend.delete();
        exp_q.delete();
        got_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        repeat (4) send(27'h5A, 8);
        drain_idle("t6");
        compare_words("t6");

        // Randomized streams with random FIFO back-pressure.
        rand_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 40; k++) begin
                d = ($urandom_range(0, 3) == 0) ? 27'h7FFFFFF : 27'($urandom);
                send(d, int'($urandom_range(0, 27)));
                if ($urandom_range(0, 9) == 0) pulse_flush();
                if ($urandom_range(0, 19) == 0) pulse_marker(16'hFFD0, 1'b0);
            end
            pulse_marker(($urandom_range(0, 1) == 0) ? 16'hFFD9 : 16'hFFD8, 1'b1);
            drain_idle("rand");
            compare_words("rand");
        end
        rand_full = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
